// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, shift modes and FSM state encoding shared by the multicycle ALU.
package alu_pkg;
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MUL   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_SHIFT = 4'b0110;
   localparam logic [2:0] SH_SRL = 3'b001;
   localparam logic [2:0] SH_SLL = 3'b010;
   localparam logic [2:0] SH_SRA = 3'b011;
   localparam logic [2:0] SH_ROR = 3'b100;
   localparam logic [2:0] SH_ROL = 3'b101;
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle; done pulses on the final iteration.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);
   logic          busy;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] mcand, mplier, acc;
   // product is the accumulator after this cycle's iteration, so it is final when done is high
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done = busy && cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt <= '0;
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt <= '0;
         mcand <= a;
         mplier <= b;
         acc <= '0;
      end else if (busy) begin
         acc <= product;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 1'b1;
         busy <= !done;
      end
   end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with registered results; MUL is iterative when
// ALU_MULTICYCLE_MUL_EN is defined, otherwise opcode MUL is reported as illegal.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   input  logic [SHW-1:0]   sh_amt,
   input  logic [2:0]       sh_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             err
);
   state_t state;
   logic accept, is_mul, mul_done, sh_err, cy, er;
   logic [WIDTH-1:0] product, sh, res;
   logic [WIDTH:0] sum, dif;
   logic [SHW:0] inv;
   assign in_ready = state == ST_IDLE || (state == ST_DONE && out_ready);
   assign out_valid = state == ST_DONE;
   assign accept = in_valid && in_ready;
`ifdef ALU_MULTICYCLE_MUL_EN
   assign is_mul = opcode == OP_MUL;
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk(clk), .rst(rst), .start(accept && is_mul), .a(a), .b(b),
      .done(mul_done), .product(product)
   );
`else
   assign is_mul = 1'b0;
   assign mul_done = 1'b0;
   assign product = '0;
`endif
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      inv = (SHW + 1)'(WIDTH) - {1'b0, sh_amt};
      sh_err = 1'b0;
      case (sh_mode)
         SH_SRL:  sh = b >> sh_amt;
         SH_SLL:  sh = b << sh_amt;
         SH_SRA:  sh = $signed(b) >>> sh_amt;
         SH_ROR:  sh = (b >> sh_amt) | (b << inv);
         SH_ROL:  sh = (b << sh_amt) | (b >> inv);
         default: begin sh = '0; sh_err = 1'b1; end
      endcase
      cy = 1'b0;
      er = 1'b0;
      case (opcode)
         OP_ADD:   begin res = sum[WIDTH-1:0]; cy = sum[WIDTH]; end
         OP_SUB:   begin res = dif[WIDTH-1:0]; cy = !dif[WIDTH]; end
         OP_OR:    res = a | b;
         OP_AND:   res = a & b;
         OP_XOR:   res = a ^ b;
         OP_SHIFT: begin res = sh; er = sh_err; end
         default:  begin res = '0; er = 1'b1; end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         result <= '0;
         carry <= 1'b0;
         zero <= 1'b0;
         err <= 1'b0;
      end else if (accept && is_mul) begin
         state <= ST_MUL;
      end else if (accept) begin
         state <= ST_DONE;
         result <= res;
         carry <= cy;
         zero <= res == '0;
         err <= er;
      end else if (mul_done) begin
         state <= ST_DONE;
         result <= product;
         carry <= 1'b0;
         zero <= product == '0;
         err <= 1'b0;
      end else if (state == ST_DONE && out_ready) begin
         state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with literal expectations plus a queue-based
// reference model that checks every presented result.
module tb_alu_multicycle;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, carry, zero, err;
   logic [W-1:0] a, b, result;
   logic [3:0] opcode;
   logic [4:0] sh_amt;
   logic [2:0] sh_mode;
   int errors = 0;
   int checks = 0;
   typedef struct packed {logic [W-1:0] r; logic c; logic z; logic e;} exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   alu_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .opcode(opcode), .sh_amt(sh_amt), .sh_mode(sh_mode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry(carry), .zero(zero), .err(err)
   );
   // shifts and rotates are modelled one bit position at a time
   function automatic exp_t model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y,
                                  logic [4:0] n, logic [2:0] m);
      exp_t e;
      logic [W:0] s;
      logic [W-1:0] t;
      e = '0;
      case (op)
         4'd0: begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.c = s[W]; end
         4'd1: begin e.r = x - y; e.c = x >= y; end
`ifdef ALU_MULTICYCLE_MUL_EN
         4'd2: e.r = x * y;
`endif
         4'd3: e.r = x | y;
         4'd4: e.r = x & y;
         4'd5: e.r = x ^ y;
         4'd6: begin
            t = y;
            case (m)
               3'd1: repeat (n) t = {1'b0, t[W-1:1]};
               3'd2: repeat (n) t = {t[W-2:0], 1'b0};
               3'd3: repeat (n) t = {t[W-1], t[W-1:1]};
               3'd4: repeat (n) t = {t[0], t[W-1:1]};
               3'd5: repeat (n) t = {t[W-2:0], t[W-1]};
               default: e.e = 1'b1;
            endcase
            e.r = e.e ? '0 : t;
         end
         default: e.e = 1'b1;
      endcase
      e.z = e.r == '0;
      return e;
   endfunction
   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (out_valid) begin
            if (q.size() == 0) chk("unexpected out_valid", 1, 0);
            else begin
               chk("model result", result, q[0].r);
               chk("model carry", W'(carry), W'(q[0].c));
               chk("model zero", W'(zero), W'(q[0].z));
               chk("model err", W'(err), W'(q[0].e));
               chk("in_ready in done", W'(in_ready), W'(out_ready));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(opcode, a, b, sh_amt, sh_mode));
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] n, input logic [2:0] m);
      int k = 0;
      opcode = op; a = x; b = y; sh_amt = n; sh_mode = m;
      in_valid = 1'b1;
      while (!in_ready && k < 100) begin step; k++; end
      if (k == 100) chk("accept timeout", 1, 0);
      step;
      in_valid = 1'b0;
   endtask
   task automatic lit(input string nm, input logic [W-1:0] r, input logic c, input logic z,
                      input logic e);
      chk({nm, " valid"}, W'(out_valid), 1);
      chk({nm, " result"}, result, r);
      chk({nm, " carry"}, W'(carry), W'(c));
      chk({nm, " zero"}, W'(zero), W'(z));
      chk({nm, " err"}, W'(err), W'(e));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, hi;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; opcode = '0; sh_amt = '0; sh_mode = '0;
      step; step;
      chk("reset out_valid", W'(out_valid), 0);
      chk("reset in_ready", W'(in_ready), 1);
      chk("reset result", result, 0);
      chk("reset flags", W'({carry, zero, err}), 0);
      rst = 1'b0;
      step;
      send(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
      lit("add wrap", 32'h0, 1, 1, 0);
      send(4'd1, 32'd10, 32'd30, 0, 0);
      lit("sub borrow", 32'hFFFF_FFEC, 0, 0, 0);
      chk("b2b in_ready", W'(in_ready), 1);
      send(4'd5, 32'hFF, 32'hF0, 0, 0);
      lit("b2b xor", 32'h0F, 0, 0, 0);
      send(4'd1, 32'd7, 32'd7, 0, 0);
      lit("sub equal", 32'h0, 1, 1, 0);
      step;
      opcode = 4'd2; a = 32'h10001; b = 32'h10001; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      n = 0; hi = 0;
      while (!out_valid && n < 100) begin
         if (in_ready) hi++;
         step;
         n++;
      end
`ifdef ALU_MULTICYCLE_MUL_EN
      chk("mul cycles", n, 32);
      chk("mul in_ready high count", hi, 0);
      lit("mul", 32'h0002_0001, 0, 0, 0);
`else
      chk("mul cycles", n, 0);
      lit("mul disabled", 32'h0, 0, 1, 1);
`endif
      step;
      send(4'd6, 32'h0, 32'h1234_5678, 4, 3'b001); lit("srl", 32'h0123_4567, 0, 0, 0);
      send(4'd6, 32'h0, 32'h1234_5678, 4, 3'b010); lit("sll", 32'h2345_6780, 0, 0, 0);
      send(4'd6, 32'h0, 32'h8000_0000, 4, 3'b011); lit("sra", 32'hF800_0000, 0, 0, 0);
      send(4'd6, 32'h0, 32'h1234_5678, 4, 3'b100); lit("ror", 32'h8123_4567, 0, 0, 0);
      send(4'd6, 32'h0, 32'h1234_5678, 4, 3'b101); lit("rol", 32'h2345_6781, 0, 0, 0);
      send(4'd6, 32'h0, 32'h1234_5678, 0, 3'b100); lit("ror0", 32'h1234_5678, 0, 0, 0);
      send(4'd6, 32'h0, 32'h8000_0001, 31, 3'b101); lit("rol31", 32'hC000_0000, 0, 0, 0);
      send(4'd6, 32'h0, 32'h1234_5678, 4, 3'b111); lit("bad mode", 32'h0, 0, 1, 1);
      send(4'd15, 32'h5, 32'h6, 0, 0); lit("bad opcode", 32'h0, 0, 1, 1);
      send(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0); lit("and", 32'hF000_F000, 0, 0, 0);
      step;
      out_ready = 1'b0;
      send(4'd0, 32'd7, 32'd8, 0, 0);
      opcode = 4'd3; a = 32'hA0; b = 32'h05; in_valid = 1'b1;
      repeat (5) begin
         step;
         lit("hold", 32'd15, 0, 0, 0);
         chk("hold in_ready", W'(in_ready), 0);
      end
      out_ready = 1'b1;
      step;
      in_valid = 1'b0;
      lit("after hold or", 32'hA5, 0, 0, 0);
      step;
      opcode = 4'd2; a = 32'hFFFF; b = 32'h1234; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      repeat (9) step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("abort out_valid", W'(out_valid), 0);
      chk("abort in_ready", W'(in_ready), 1);
      chk("abort result", result, 0);
      chk("abort flags", W'({carry, zero, err}), 0);
      repeat (40) begin
         chk("no stale result", W'(out_valid), 0);
         step;
      end
      send(4'd0, 32'd2, 32'd3, 0, 0);
      lit("add after reset", 32'd5, 0, 0, 0);
      step; step;
      chk("queue drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
